// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg: shared sizes and FSM state encoding for the FIR sequencer
package fir_seq_pkg;
    localparam int NTAPS      = 32;
    localparam int DATA_W     = 16;
    localparam int CFG_ADDR_W = 5;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
endpackage

// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: shadow/active coefficient banks with an atomic commit that only lands while the sequencer is idle
module fir_coeff_bank #(
    parameter int NTAPS  = fir_seq_pkg::NTAPS,
    parameter int DATA_W = fir_seq_pkg::DATA_W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                idle,
    input  logic                                cfg_we,
    input  logic [fir_seq_pkg::CFG_ADDR_W-1:0]  cfg_addr,
    input  logic [DATA_W-1:0]                   cfg_wdata,
    input  logic                                cfg_commit,
    output logic                                cfg_pending,
    output logic [NTAPS*DATA_W-1:0]             coeff_active
);
    import fir_seq_pkg::*;
    logic pending;
    logic apply;
    // the commit edge itself counts, so a commit requested while idle never shows as pending
    assign apply       = idle && (pending || cfg_commit);
    assign cfg_pending = pending;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pending <= 1'b0;
        else        pending <= !apply && (pending || cfg_commit);
    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        logic [DATA_W-1:0] shadow;
        logic [DATA_W-1:0] active;
        logic              hit;
        assign hit = cfg_we && cfg_addr == CFG_ADDR_W'(k);
        // a write landing on the apply edge is forwarded straight into the active copy
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                shadow <= '0;
                active <= '0;
            end else begin
                if (hit)   shadow <= cfg_wdata;
                if (apply) active <= hit ? cfg_wdata : shadow;
            end
        assign coeff_active[k*DATA_W +: DATA_W] = active;
    end
endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sample/result stream sequencer for the 32-tap FIR with committed coefficient banks
// Optional WAIT-state watchdog and sticky err flag enabled by defining FIR_SEQ_TIMEOUT_EN.
module fir_seq_ctrl #(
    parameter int NTAPS          = fir_seq_pkg::NTAPS,
    parameter int DATA_W         = fir_seq_pkg::DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_W-1:0]                   in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_W-1:0]                   out_data,
    input  logic                                cfg_we,
    input  logic [fir_seq_pkg::CFG_ADDR_W-1:0]  cfg_addr,
    input  logic [DATA_W-1:0]                   cfg_wdata,
    input  logic                                cfg_commit,
    output logic                                cfg_pending,
    output logic                                fir_run,
    input  logic                                fir_busy,
    output logic [DATA_W-1:0]                   fir_sample,
    input  logic [DATA_W-1:0]                   fir_result,
    output logic [NTAPS*DATA_W-1:0]             coeff_active,
    output logic                                err,
    input  logic                                err_clr
);
    import fir_seq_pkg::*;
    state_t state, state_nx;
    logic   accept, done, timeout;
    assign in_ready = state == IDLE && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign done     = state == WAIT && !fir_busy;
    // run follows the async-reset state register, so it drops the moment reset asserts
    assign fir_run  = state == LAUNCH;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? LAUNCH : IDLE;
            LAUNCH:  state_nx = WAIT;
            WAIT:    state_nx = (done || timeout) ? IDLE : WAIT;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            fir_sample <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            if (accept) fir_sample <= in_data;
            if (done)   out_data   <= fir_result;
            out_valid <= done || (out_valid && !out_ready);
        end
`ifdef FIR_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_cnt;
    logic          err_q;
    assign timeout = state == WAIT && fir_busy && wd_cnt == CW'(TIMEOUT_CYCLES - 1);
    assign err     = err_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= state == WAIT ? wd_cnt + 1'b1 : '0;
            err_q  <= !err_clr && (err_q || timeout);
        end
`else
    logic unused_wd;
    assign timeout   = 1'b0;
    assign err       = 1'b0;
    assign unused_wd = err_clr | (TIMEOUT_CYCLES == 0);
`endif
    fir_coeff_bank #(.NTAPS(NTAPS), .DATA_W(DATA_W)) u_bank (
        .clk          (clk),
        .rst_n        (rst_n),
        .idle         (state == IDLE),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_commit   (cfg_commit),
        .cfg_pending  (cfg_pending),
        .coeff_active (coeff_active)
    );
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: directed bench for fir_seq_ctrl with a 3-cycle-busy FIR model (coeff0-only product >> 15)
module tb_fir_seq_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [15:0]  in_data, out_data, cfg_wdata, fir_sample, fir_result;
    logic         cfg_we, cfg_commit, cfg_pending, fir_run, fir_busy, err, err_clr;
    logic [4:0]   cfg_addr;
    logic [511:0] coeff_active;
    logic [1:0]   fir_cnt = '0;
    logic         stuck = 1'b0;
    int           n_chk = 0;
    int           n_pass = 0;
    int           lat;
    logic         saw;

    always #5 clk = ~clk;

    fir_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
        .cfg_pending(cfg_pending), .fir_run(fir_run), .fir_busy(fir_busy), .fir_sample(fir_sample),
        .fir_result(fir_result), .coeff_active(coeff_active), .err(err), .err_clr(err_clr)
    );

    // FIR stand-in: busy for 3 cycles after the run edge, result = sample*coeff0 >> 15
    assign fir_busy = fir_run || fir_cnt != 0 || stuck;
    always @(posedge clk)
        if (fir_run) begin
            fir_cnt    <= 2'd3;
            fir_result <= 16'((32'(fir_sample) * 32'(coeff_active[15:0])) >> 15);
        end else if (fir_cnt != 0) fir_cnt <= fir_cnt - 2'd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run_sample(input logic [15:0] s, output int l);
        in_valid = 1'b1;
        in_data  = s;
        @(negedge clk);
        in_valid = 1'b0;
        check("run_pulse", fir_run, 1);
        check("sample_latched", fir_sample, s);
        @(negedge clk);
        check("run_one_cycle", fir_run, 0);
        l = 2;
        while (!out_valid && l < 40) begin
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        in_valid = 0; in_data = 0; out_ready = 0; cfg_we = 0; cfg_addr = 0;
        cfg_wdata = 0; cfg_commit = 0; err_clr = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_fir_run", fir_run, 0);
        check("rst_fir_sample", fir_sample, 0);
        check("rst_coeff", |coeff_active, 0);
        check("rst_pending", cfg_pending, 0);
        check("rst_err", err, 0);
        // write + commit while idle
        cfg_we = 1; cfg_addr = 0; cfg_wdata = 16'h7FFF; cfg_commit = 1;
        @(negedge clk);
        cfg_we = 0; cfg_commit = 0;
        check("commit_idle_coeff0", coeff_active[15:0], 16'h7FFF);
        check("commit_idle_pending", cfg_pending, 0);
        run_sample(16'h4000, lat);
        check("lat_first", lat, 6);
        check("out_first", out_data, 16'h3FFF);
        check("in_ready_busy_out", in_ready, 0);
        // backpressure: result held, next sample waits
        in_valid = 1; in_data = 16'h2000;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, 16'h3FFF);
        end
        out_ready = 1;
        #1;
        check("release_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        check("release_out_valid", out_valid, 0);
        check("release_run", fir_run, 1);
        check("release_sample", fir_sample, 16'h2000);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("lat_second", lat, 6);
        check("out_second", out_data, 16'h1FFF);
        // commit during WAIT stays pending until idle
        @(negedge clk);
        cfg_we = 1; cfg_addr = 0; cfg_wdata = 16'h4000;
        @(negedge clk);
        cfg_we = 0;
        check("shadow_only_coeff0", coeff_active[15:0], 16'h7FFF);
        in_valid = 1; in_data = 16'h4000;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        cfg_commit = 1;
        @(negedge clk);
        check("wait_pending", cfg_pending, 1);
        check("wait_coeff_hold", coeff_active[15:0], 16'h7FFF);
        @(negedge clk);
        cfg_commit = 0;
        lat = 4;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("lat_commit", lat, 6);
        check("out_old_coeff", out_data, 16'h3FFF);
        check("idle_pending_still", cfg_pending, 1);
        check("idle_coeff_still", coeff_active[15:0], 16'h7FFF);
        @(negedge clk);
        check("applied_pending", cfg_pending, 0);
        check("applied_coeff0", coeff_active[15:0], 16'h4000);
        // write + commit in one idle cycle
        cfg_we = 1; cfg_addr = 5; cfg_wdata = 16'h1234; cfg_commit = 1;
        @(negedge clk);
        cfg_we = 0; cfg_commit = 0;
        check("same_cycle_coeff5", coeff_active[95:80], 16'h1234);
        check("same_cycle_pending", cfg_pending, 0);
        cfg_we = 1; cfg_addr = 31; cfg_wdata = 16'hBEEF;
        @(negedge clk);
        cfg_we = 0;
        check("coeff31_shadow", coeff_active[511:496], 0);
        cfg_commit = 1;
        @(negedge clk);
        cfg_commit = 0;
        check("coeff31_commit", coeff_active[511:496], 16'hBEEF);
        run_sample(16'h4000, lat);
        check("lat_new_coeff", lat, 6);
        check("out_new_coeff", out_data, 16'h2000);
        @(negedge clk);
`ifdef FIR_SEQ_TIMEOUT_EN
        stuck = 1;
        in_valid = 1; in_data = 16'h0001;
        @(negedge clk);
        in_valid = 0;
        lat = 1; saw = 0;
        while (!in_ready && lat < 200) begin
            @(negedge clk);
            lat++;
            saw |= out_valid;
        end
        check("tmo_lat", lat, 66);
        check("tmo_err", err, 1);
        check("tmo_no_valid", saw, 0);
        stuck = 0;
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        check("tmo_err_clr", err, 0);
`else
        check("err_tied", err, 0);
`endif
        // reset during LAUNCH: run drops immediately
        in_valid = 1; in_data = 16'h1111;
        @(negedge clk);
        in_valid = 0;
        check("pre_rst_run", fir_run, 1);
        rst_n = 0;
        #1;
        check("rst_launch_run", fir_run, 0);
        check("rst_launch_sample", fir_sample, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        // reset during WAIT: outputs return to reset values, no result follows
        in_valid = 1; in_data = 16'h2222;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        check("rst_wait_run", fir_run, 0);
        check("rst_wait_sample", fir_sample, 0);
        check("rst_wait_out_valid", out_valid, 0);
        check("rst_wait_out_data", out_data, 0);
        check("rst_wait_coeff", |coeff_active, 0);
        check("rst_wait_pending", cfg_pending, 0);
        @(negedge clk);
        rst_n = 1;
        saw = 0;
        repeat (10) begin
            @(negedge clk);
            saw |= out_valid;
        end
        check("rst_no_result", saw, 0);
        check("rst_in_ready_after", in_ready, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
